// File: rtl/mem_access.sv
// Memory-access stage: ALU results pass straight to writeback, loads and
// stores run one request/response transaction on the data-memory port.
module mem_access (
    input  logic        clk,
    input  logic        rstn,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_store_data,
    input  logic [31:0] in_result,
    input  logic        in_reg_write_enabled,
    input  logic [4:0]  in_reg_write_dest,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,

    output logic        wb_valid,
    output logic        wb_reg_write_enabled,
    output logic [4:0]  wb_reg_write_dest,
    output logic [31:0] wb_data,
    output logic        wb_fault
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REGW  = 5;
    localparam int unsigned STRBW = XLEN / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state, state_d;

    logic              mem_req_valid_d;
    logic              mem_req_we_d;
    logic [XLEN-1:0]   mem_req_addr_d;
    logic [XLEN-1:0]   mem_req_wdata_d;
    logic [STRBW-1:0]  mem_req_wstrb_d;

    logic              wb_valid_d;
    logic              wb_reg_write_enabled_d;
    logic [REGW-1:0]   wb_reg_write_dest_d;
    logic [XLEN-1:0]   wb_data_d;
    logic              wb_fault_d;

    // Attributes of the in-flight memory op needed after the request phase
    logic [2:0]        lat_funct3, lat_funct3_d;
    logic [1:0]        lat_off, lat_off_d;
    logic              lat_rwe, lat_rwe_d;
    logic [REGW-1:0]   lat_dest, lat_dest_d;

    logic              accept;
    logic              acc_is_mem;
    logic              acc_f3_legal;
    logic              acc_misaligned;
    logic              acc_fault;

    // Funct3 codes that name a real memory access width
    function automatic logic f3_legal(input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_legal = 1'b1;
            default:                        f3_legal = 1'b0;
        endcase
    endfunction

    // Replicate store data so the addressed lanes carry it regardless of offset
    function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] f3,
                                                    input logic [XLEN-1:0] d);
        case (f3[1:0])
            2'b00:   store_wdata = {4{d[7:0]}};
            2'b01:   store_wdata = {2{d[15:0]}};
            default: store_wdata = d;
        endcase
    endfunction

    // Byte-lane strobes for the access size at the given offset
    function automatic logic [STRBW-1:0] store_wstrb(input logic [2:0] f3,
                                                     input logic [1:0] off);
        case (f3[1:0])
            2'b00:   store_wstrb = 4'b0001 << off;
            2'b01:   store_wstrb = 4'b0011 << off;
            default: store_wstrb = 4'b1111;
        endcase
    endfunction

    // Pick the addressed byte/half out of the aligned word and extend it
    function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3,
                                                     input logic [1:0] off,
                                                     input logic [XLEN-1:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            F3_B:    load_extract = {{24{b[7]}}, b};
            F3_BU:   load_extract = {24'h000000, b};
            F3_H:    load_extract = {{16{h[15]}}, h};
            F3_HU:   load_extract = {16'h0000, h};
            default: load_extract = rd;
        endcase
    endfunction

    // Ready only when idle and out of reset
    assign in_ready = (state == IDLE) && rstn;
    assign accept   = in_valid && in_ready;

    // Decode of the offered instruction
    assign acc_is_mem     = in_load || in_store;
    assign acc_f3_legal   = f3_legal(in_funct3);
    assign acc_misaligned = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                            ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
    assign acc_fault      = (in_load && in_store) || !acc_f3_legal || acc_misaligned;

    // Next-state and next-output logic
    always_comb begin
        state_d                = state;
        mem_req_valid_d        = mem_req_valid;
        mem_req_we_d           = mem_req_we;
        mem_req_addr_d         = mem_req_addr;
        mem_req_wdata_d        = mem_req_wdata;
        mem_req_wstrb_d        = mem_req_wstrb;
        wb_valid_d             = 1'b0;
        wb_reg_write_enabled_d = wb_reg_write_enabled;
        wb_reg_write_dest_d    = wb_reg_write_dest;
        wb_data_d              = wb_data;
        wb_fault_d             = wb_fault;
        lat_funct3_d           = lat_funct3;
        lat_off_d              = lat_off;
        lat_rwe_d              = lat_rwe;
        lat_dest_d             = lat_dest;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (!acc_is_mem) begin
                        wb_valid_d             = 1'b1;
                        wb_fault_d             = 1'b0;
                        wb_data_d              = in_result;
                        wb_reg_write_dest_d    = in_reg_write_dest;
                        wb_reg_write_enabled_d = in_reg_write_enabled &&
                                                 (in_reg_write_dest != '0);
                    end else if (acc_fault) begin
                        wb_valid_d             = 1'b1;
                        wb_fault_d             = 1'b1;
                        wb_data_d              = '0;
                        wb_reg_write_dest_d    = in_reg_write_dest;
                        wb_reg_write_enabled_d = 1'b0;
                    end else begin
                        state_d         = REQ;
                        mem_req_valid_d = 1'b1;
                        mem_req_we_d    = in_store;
                        mem_req_addr_d  = {in_addr[XLEN-1:2], 2'b00};
                        mem_req_wdata_d = in_store ? store_wdata(in_funct3, in_store_data) : '0;
                        mem_req_wstrb_d = in_store ? store_wstrb(in_funct3, in_addr[1:0]) : '0;
                        lat_funct3_d    = in_funct3;
                        lat_off_d       = in_addr[1:0];
                        lat_rwe_d       = in_reg_write_enabled;
                        lat_dest_d      = in_reg_write_dest;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    if (mem_req_we) begin
                        state_d                = IDLE;
                        wb_valid_d             = 1'b1;
                        wb_fault_d             = 1'b0;
                        wb_reg_write_dest_d    = lat_dest;
                        wb_reg_write_enabled_d = 1'b0;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (mem_resp_valid) begin
                    state_d                = IDLE;
                    wb_valid_d             = 1'b1;
                    wb_fault_d             = 1'b0;
                    wb_data_d              = load_extract(lat_funct3, lat_off, mem_resp_rdata);
                    wb_reg_write_dest_d    = lat_dest;
                    wb_reg_write_enabled_d = lat_rwe && (lat_dest != '0);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state                <= IDLE;
            mem_req_valid        <= 1'b0;
            mem_req_we           <= 1'b0;
            mem_req_addr         <= '0;
            mem_req_wdata        <= '0;
            mem_req_wstrb        <= '0;
            wb_valid             <= 1'b0;
            wb_reg_write_enabled <= 1'b0;
            wb_reg_write_dest    <= '0;
            wb_data              <= '0;
            wb_fault             <= 1'b0;
            lat_funct3           <= '0;
            lat_off              <= '0;
            lat_rwe              <= 1'b0;
            lat_dest             <= '0;
        end else begin
            state                <= state_d;
            mem_req_valid        <= mem_req_valid_d;
            mem_req_we           <= mem_req_we_d;
            mem_req_addr         <= mem_req_addr_d;
            mem_req_wdata        <= mem_req_wdata_d;
            mem_req_wstrb        <= mem_req_wstrb_d;
            wb_valid             <= wb_valid_d;
            wb_reg_write_enabled <= wb_reg_write_enabled_d;
            wb_reg_write_dest    <= wb_reg_write_dest_d;
            wb_data              <= wb_data_d;
            wb_fault             <= wb_fault_d;
            lat_funct3           <= lat_funct3_d;
            lat_off              <= lat_off_d;
            lat_rwe              <= lat_rwe_d;
            lat_dest             <= lat_dest_d;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: scenario tasks drive stimulus, a scoreboard queue
// holds expected writebacks that the negedge monitor pops on every wb pulse.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_load = 1'b0;
    logic        in_store = 1'b0;
    logic [2:0]  in_funct3 = 3'b000;
    logic [31:0] in_addr = '0;
    logic [31:0] in_store_data = '0;
    logic [31:0] in_result = '0;
    logic        in_reg_write_enabled = 1'b0;
    logic [4:0]  in_reg_write_dest = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_rdata = '0;
    logic        wb_valid;
    logic        wb_reg_write_enabled;
    logic [4:0]  wb_reg_write_dest;
    logic [31:0] wb_data;
    logic        wb_fault;

    typedef struct packed {
        logic [31:0] data;
        logic        fault;
        logic        rwe;
        logic [4:0]  dest;
        logic        chk_data;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    wb_exp_t mon_e;
    int total = 0;
    int bad = 0;

    mem_access dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_load(in_load), .in_store(in_store), .in_funct3(in_funct3),
        .in_addr(in_addr), .in_store_data(in_store_data), .in_result(in_result),
        .in_reg_write_enabled(in_reg_write_enabled), .in_reg_write_dest(in_reg_write_dest),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .wb_valid(wb_valid), .wb_reg_write_enabled(wb_reg_write_enabled),
        .wb_reg_write_dest(wb_reg_write_dest), .wb_data(wb_data), .wb_fault(wb_fault)
    );

    always #5 clk = ~clk;

    // Scoreboard: every writeback pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rstn && wb_valid === 1'b1) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL wb_unexpected got data=%h fault=%b rwe=%b dest=%0d want no pulse",
                         wb_data, wb_fault, wb_reg_write_enabled, wb_reg_write_dest);
            end else begin
                mon_e = exp_q.pop_front();
                if (wb_fault !== mon_e.fault || wb_reg_write_enabled !== mon_e.rwe ||
                    wb_reg_write_dest !== mon_e.dest ||
                    (mon_e.chk_data && wb_data !== mon_e.data)) begin
                    bad = bad + 1;
                    $display("FAIL wb_payload got data=%h fault=%b rwe=%b dest=%0d want data=%h(chk=%b) fault=%b rwe=%b dest=%0d",
                             wb_data, wb_fault, wb_reg_write_enabled, wb_reg_write_dest,
                             mon_e.data, mon_e.chk_data, mon_e.fault, mon_e.rwe, mon_e.dest);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] res, input logic rwe, input logic [4:0] dest);
        in_valid = 1'b1; in_load = ld; in_store = st; in_funct3 = f3;
        in_addr = addr; in_store_data = sdata; in_result = res;
        in_reg_write_enabled = rwe; in_reg_write_dest = dest;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total = total + 1;
        if ({mem_req_valid, mem_req_we, wb_valid, wb_fault, wb_reg_write_enabled} !== 5'b0 ||
            mem_req_addr !== 32'h0 || mem_req_wdata !== 32'h0 || mem_req_wstrb !== 4'h0 ||
            wb_data !== 32'h0 || wb_reg_write_dest !== 5'd0) begin
            bad = bad + 1;
            $display("FAIL reset_outputs got req=%b addr=%h wdata=%h wstrb=%b wb=%b data=%h want all zero",
                     mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wstrb, wb_valid, wb_data);
        end
        total = total + 1;
        if (in_ready !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL ready_in_reset got=%b want=0", in_ready);
        end
        tick();
        rstn = 1'b1;
        @(negedge clk);
        total = total + 1;
        if (in_ready !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL ready_after_reset got=%b want=1", in_ready);
        end
    endtask

    task automatic test_alu_passthrough();
        tick();
        set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_1234, 1'b1, 5'd5);
        exp_q.push_back('{data: 32'h0000_1234, fault: 1'b0, rwe: 1'b1, dest: 5'd5, chk_data: 1'b1});
        @(negedge clk);
        tick();
        set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_5678, 1'b1, 5'd7);
        exp_q.push_back('{data: 32'h0000_5678, fault: 1'b0, rwe: 1'b1, dest: 5'd7, chk_data: 1'b1});
        @(negedge clk);
        total = total + 1;
        if (wb_valid !== 1'b1 || in_ready !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL alu_b2b_1 got wb=%b ready=%b want 1 1", wb_valid, in_ready);
        end
        tick();
        set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_9ABC, 1'b1, 5'd0);
        exp_q.push_back('{data: 32'h0000_9ABC, fault: 1'b0, rwe: 1'b0, dest: 5'd0, chk_data: 1'b1});
        @(negedge clk);
        total = total + 1;
        if (wb_valid !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL alu_b2b_2 got wb=%b want=1", wb_valid);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total = total + 1;
        if (wb_valid !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL alu_b2b_3 got wb=%b want=1", wb_valid);
        end
        tick();
        @(negedge clk);
        total = total + 1;
        if (wb_valid !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL alu_idle_nowb got wb=%b want=0", wb_valid);
        end
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sdata, input int delay,
                            input logic [31:0] e_addr, input logic [31:0] e_wdata,
                            input logic [3:0] e_strb);
        tick();
        set_op(1'b0, 1'b1, f3, addr, sdata, 32'h0, 1'b1, 5'd3);
        @(negedge clk);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < delay; i++) begin
            if (i == delay - 1) begin
                mem_req_ready = 1'b1;
                exp_q.push_back('{data: 32'h0, fault: 1'b0, rwe: 1'b0, dest: 5'd3, chk_data: 1'b0});
            end
            @(negedge clk);
            total = total + 1;
            if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b1 || mem_req_addr !== e_addr ||
                mem_req_wdata !== e_wdata || mem_req_wstrb !== e_strb || in_ready !== 1'b0 ||
                wb_valid !== 1'b0) begin
                bad = bad + 1;
                $display("FAIL store_req cyc=%0d got v=%b we=%b addr=%h wdata=%h strb=%b rdy=%b wb=%b want 1 1 %h %h %b 0 0",
                         i, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
                         in_ready, wb_valid, e_addr, e_wdata, e_strb);
            end
            tick();
        end
        mem_req_ready = 1'b0;
        @(negedge clk);
        total = total + 1;
        if (wb_valid !== 1'b1 || mem_req_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL store_done got wb=%b req=%b rdy=%b want 1 0 1", wb_valid, mem_req_valid, in_ready);
        end
        tick();
        @(negedge clk);
        total = total + 1;
        if (wb_valid !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL store_wb_once got wb=%b want=0", wb_valid);
        end
    endtask

    task automatic test_store();
        do_store(3'b000, 32'h0000_0103, 32'h0000_00AB, 3, 32'h0000_0100, 32'hABAB_ABAB, 4'b1000);
        do_store(3'b001, 32'h0000_0102, 32'h1234_BEEF, 1, 32'h0000_0100, 32'hBEEF_BEEF, 4'b1100);
        do_store(3'b010, 32'h0000_0104, 32'hCAFE_F00D, 2, 32'h0000_0104, 32'hCAFE_F00D, 4'b1111);
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] e_data);
        tick();
        set_op(1'b1, 1'b0, f3, addr, 32'h0, 32'h0, 1'b1, 5'd4);
        @(negedge clk);
        tick();
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        total = total + 1;
        if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_wstrb !== 4'b0000 ||
            mem_req_addr !== {addr[31:2], 2'b00}) begin
            bad = bad + 1;
            $display("FAIL load_req got v=%b we=%b strb=%b addr=%h want 1 0 0000 %h",
                     mem_req_valid, mem_req_we, mem_req_wstrb, mem_req_addr, {addr[31:2], 2'b00});
        end
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdata;
        exp_q.push_back('{data: e_data, fault: 1'b0, rwe: 1'b1, dest: 5'd4, chk_data: 1'b1});
        @(negedge clk);
        total = total + 1;
        if (mem_req_valid !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL load_resp_wait got req=%b wb=%b rdy=%b want 0 0 0", mem_req_valid, wb_valid, in_ready);
        end
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        total = total + 1;
        if (wb_valid !== 1'b1 || wb_data !== e_data) begin
            bad = bad + 1;
            $display("FAIL load_data f3=%b got wb=%b data=%h want 1 %h", f3, wb_valid, wb_data, e_data);
        end
        tick();
        @(negedge clk);
    endtask

    task automatic test_load();
        do_load(3'b000, 32'h0000_0202, 32'h0080_FF00, 32'hFFFF_FF80);
        do_load(3'b100, 32'h0000_0202, 32'h0080_FF00, 32'h0000_0080);
        do_load(3'b001, 32'h0000_0202, 32'h8001_0000, 32'hFFFF_8001);
        do_load(3'b101, 32'h0000_0200, 32'h1234_8765, 32'h0000_8765);
        do_load(3'b010, 32'h0000_0208, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    endtask

    task automatic do_fault(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr);
        tick();
        set_op(ld, st, f3, addr, 32'h5555_5555, 32'h0, 1'b1, 5'd6);
        exp_q.push_back('{data: 32'h0, fault: 1'b1, rwe: 1'b0, dest: 5'd6, chk_data: 1'b0});
        @(negedge clk);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total = total + 1;
        if (mem_req_valid !== 1'b0 || wb_valid !== 1'b1 || wb_fault !== 1'b1 || in_ready !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL fault_pulse addr=%h got req=%b wb=%b fault=%b rdy=%b want 0 1 1 1",
                     addr, mem_req_valid, wb_valid, wb_fault, in_ready);
        end
        tick();
        @(negedge clk);
        total = total + 1;
        if (mem_req_valid !== 1'b0 || wb_valid !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL fault_nobus got req=%b wb=%b want 0 0", mem_req_valid, wb_valid);
        end
    endtask

    task automatic test_misaligned();
        do_fault(1'b1, 1'b0, 3'b010, 32'h0000_0301);
        do_fault(1'b0, 1'b1, 3'b001, 32'h0000_0303);
        do_fault(1'b1, 1'b0, 3'b011, 32'h0000_0300);
        do_fault(1'b1, 1'b1, 3'b010, 32'h0000_0300);
    endtask

    task automatic test_reset_mid();
        tick();
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h0, 1'b1, 5'd8);
        @(negedge clk);
        tick();
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        tick();
        mem_req_ready = 1'b0;
        @(negedge clk);
        tick();
        rstn = 1'b0;
        @(negedge clk);
        total = total + 1;
        if ({mem_req_valid, mem_req_we, wb_valid, wb_fault, wb_reg_write_enabled} !== 5'b0 ||
            mem_req_addr !== 32'h0 || mem_req_wstrb !== 4'h0 || wb_reg_write_dest !== 5'd0) begin
            bad = bad + 1;
            $display("FAIL midreset_outputs got req=%b addr=%h wb=%b want zero", mem_req_valid, mem_req_addr, wb_valid);
        end
        tick();
        rstn = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total = total + 1;
        if (in_ready !== 1'b1 || mem_req_valid !== 1'b0 || wb_valid !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL midreset_release got rdy=%b req=%b wb=%b want 1 0 0", in_ready, mem_req_valid, wb_valid);
        end
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        total = total + 1;
        if (wb_valid !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL stale_resp got wb=%b want=0", wb_valid);
        end
    endtask

    task automatic test_back_to_back();
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h1111_1111;
        @(negedge clk);
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        total = total + 1;
        if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL spurious_resp got wb=%b rdy=%b want 0 1", wb_valid, in_ready);
        end
        tick();
        set_op(1'b0, 1'b1, 3'b010, 32'h0000_0500, 32'h0BAD_F00D, 32'h0, 1'b0, 5'd9);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tick();
            in_addr = 32'h0000_0600 + 32'(i * 4);
            in_store_data = 32'h7777_0000 + 32'(i);
            if (i == 2) begin
                in_valid = 1'b0;
                mem_req_ready = 1'b1;
                exp_q.push_back('{data: 32'h0, fault: 1'b0, rwe: 1'b0, dest: 5'd9, chk_data: 1'b0});
            end
            @(negedge clk);
            total = total + 1;
            if (in_ready !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_0500 ||
                mem_req_wdata !== 32'h0BAD_F00D) begin
                bad = bad + 1;
                $display("FAIL held_valid cyc=%0d got rdy=%b req=%b addr=%h wdata=%h want 0 1 00000500 0badf00d",
                         i, in_ready, mem_req_valid, mem_req_addr, mem_req_wdata);
            end
        end
        tick();
        mem_req_ready = 1'b0;
        @(negedge clk);
        total = total + 1;
        if (wb_valid !== 1'b1 || in_ready !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL held_done got wb=%b rdy=%b want 1 1", wb_valid, in_ready);
        end
        tick();
        @(negedge clk);
        total = total + 1;
        if (wb_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL held_no_reaccept got wb=%b req=%b want 0 0", wb_valid, mem_req_valid);
        end
    endtask

    initial begin
        test_reset();
        test_alu_passthrough();
        test_store();
        test_load();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL scoreboard_drain got=%0d pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
